// File: rtl/comma_word_aligner_if.sv
// Symbol-side bundle of the comma word aligner: sliding window in, aligned
// symbol stream and status out.
interface comma_word_aligner_if #(
   parameter int DATA_WIDTH = 10
);
   logic [DATA_WIDTH-1:0] Data_In;
   logic [DATA_WIDTH-1:0] Symbol;
   logic                  Symbol_Valid;
   logic                  Comma_Det;
   logic                  Symbol_Lock;

   // Upstream shift register / downstream decoder side
   modport master (
      output Data_In,
      input  Symbol,
      input  Symbol_Valid,
      input  Comma_Det,
      input  Symbol_Lock
   );

   // Aligner side
   modport slave (
      input  Data_In,
      output Symbol,
      output Symbol_Valid,
      output Comma_Det,
      output Symbol_Lock
   );
endinterface

// File: rtl/comma_word_aligner.sv
// K28.5 comma word aligner: finds the 10-bit symbol boundary in the
// recovered bit stream, emits one aligned symbol every 10 bit clocks and
// reports symbol lock after LOCK_COMMAS consecutive boundary-aligned commas.
module comma_word_aligner #(
   parameter int DATA_WIDTH  = 10,
   parameter int LOCK_COMMAS = 3
) (
   input  logic                   Recovered_Bit_Clk,
   input  logic                   Rst_n,
   comma_word_aligner_if.slave    bus
);

   if (DATA_WIDTH != 10 || LOCK_COMMAS < 1 || LOCK_COMMAS > 15) begin : g_bad_param
      $error("comma_word_aligner: DATA_WIDTH must be 10 and LOCK_COMMAS 1..15");
   end

   localparam logic [DATA_WIDTH-1:0] K28_5_RDN = DATA_WIDTH'(10'h17C);
   localparam logic [DATA_WIDTH-1:0] K28_5_RDP = DATA_WIDTH'(10'h283);
   localparam logic [3:0]            LOCK_CNT  = 4'(LOCK_COMMAS);
   localparam logic [3:0]            LAST_PH   = 4'd9;

   typedef enum logic [1:0] {
      SEARCH,
      ALIGNED,
      LOCKED
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [3:0]            ccnt_q, ccnt_d;
   logic [DATA_WIDTH-1:0] sym_q, sym_d;
   logic                  valid_q, valid_d;
   logic                  det_q, det_d;
   logic                  lock_q, lock_d;

   logic                  comma;
   logic                  boundary;
   logic                  realign;

   // Next-state: phase tracking, comma qualification and lock state machine
   always_comb begin
      comma    = (bus.Data_In == K28_5_RDN) || (bus.Data_In == K28_5_RDP);
      boundary = (state_q != SEARCH) && (cnt_q == LAST_PH);
      // In SEARCH boundary is never true, so every comma there is a realign
      realign  = comma && !boundary;

      state_d  = state_q;
      cnt_d    = cnt_q;
      ccnt_d   = ccnt_q;
      sym_d    = sym_q;
      valid_d  = 1'b0;
      det_d    = comma;

      if (state_q != SEARCH) begin
         if (boundary) begin
            sym_d   = bus.Data_In;
            valid_d = 1'b1;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q + 4'd1;
         end
      end

      if (realign) begin
         sym_d   = bus.Data_In;
         valid_d = 1'b1;
         cnt_d   = '0;
         ccnt_d  = 4'd1;
         state_d = (state_q == SEARCH && LOCK_CNT == 4'd1) ? LOCKED : ALIGNED;
      end else if (comma) begin
         if (ccnt_q < LOCK_CNT) begin
            ccnt_d = ccnt_q + 4'd1;
         end
         if (state_q == ALIGNED && ({1'b0, ccnt_q} + 5'd1) >= {1'b0, LOCK_CNT}) begin
            state_d = LOCKED;
         end
      end

      lock_d = (state_d == LOCKED);
   end

   // State and registered outputs, asynchronously cleared
   always_ff @(posedge Recovered_Bit_Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= SEARCH;
         cnt_q   <= '0;
         ccnt_q  <= '0;
         sym_q   <= '0;
         valid_q <= 1'b0;
         det_q   <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ccnt_q  <= ccnt_d;
         sym_q   <= sym_d;
         valid_q <= valid_d;
         det_q   <= det_d;
         lock_q  <= lock_d;
      end
   end

   assign bus.Symbol       = sym_q;
   assign bus.Symbol_Valid = valid_q;
   assign bus.Comma_Det    = det_q;
   assign bus.Symbol_Lock  = lock_q;

endmodule

// File: tb/tb_comma_word_aligner.sv
// Bench for comma_word_aligner: serial bit stream through a shift register
// model, outputs compared every clock against a time-index reference model.
module tb_comma_word_aligner;

   localparam int LOCK = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   comma_word_aligner_if #(.DATA_WIDTH(10)) bus ();

   comma_word_aligner #(
      .DATA_WIDTH  (10),
      .LOCK_COMMAS (LOCK)
   ) dut (
      .Recovered_Bit_Clk (clk),
      .Rst_n             (rst_n),
      .bus               (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // upstream shift register (newest bit enters at [9])
   logic [9:0] win;

   // reference model: boundary grid anchored at the last realigning comma
   int         t;
   int         align_t;
   int         n_commas;
   logic       exp_valid, exp_det, exp_lock;
   logic [9:0] exp_sym;

   // planned bit stream for a scenario
   logic       plan[$];
   logic [9:0] plan_win;

   function automatic logic is_comma(input logic [9:0] w);
      return (w == 10'h17C) || (w == 10'h283);
   endfunction

   function automatic logic [9:0] data_sym();
      case ($urandom_range(0, 3))
         0:       return 10'h2AA;
         1:       return 10'h155;
         2:       return 10'h333;
         default: return 10'h0CC;
      endcase
   endfunction

   task automatic model_reset();
      align_t   = -1;
      n_commas  = 0;
      exp_valid = 1'b0;
      exp_det   = 1'b0;
      exp_lock  = 1'b0;
      exp_sym   = '0;
   endtask

   task automatic plan_start();
      plan.delete();
      plan_win = win;
   endtask

   task automatic plan_bit(input logic b);
      plan.push_back(b);
      plan_win = {b, plan_win[9:1]};
   endtask

   // random bits that never complete a comma window
   task automatic plan_nc(input int cnt);
      logic b;
      for (int i = 0; i < cnt; i++) begin
         b = 1'($urandom_range(0, 1));
         if (is_comma({b, plan_win[9:1]})) b = ~b;
         plan_bit(b);
      end
   endtask

   task automatic plan_sym(input logic [9:0] s);
      for (int i = 0; i < 10; i++) plan_bit(s[i]);
   endtask

   // shift one bit in, clock it, and advance the reference model
   task automatic send_bit(input logic b);
      logic c;
      @(negedge clk);
      win         = {b, win[9:1]};
      bus.Data_In = win;
      @(posedge clk);
      t++;
      c         = is_comma(win);
      exp_det   = c;
      exp_valid = 1'b0;
      if (align_t < 0) begin
         if (c) begin
            align_t   = t;
            n_commas  = 1;
            exp_valid = 1'b1;
            exp_sym   = win;
            exp_lock  = (LOCK == 1);
         end
      end else if ((t - align_t) % 10 == 0) begin
         exp_valid = 1'b1;
         exp_sym   = win;
         if (c) begin
            if (n_commas < LOCK) n_commas++;
            if (n_commas >= LOCK) exp_lock = 1'b1;
         end
      end else if (c) begin
         align_t   = t;
         n_commas  = 1;
         exp_valid = 1'b1;
         exp_sym   = win;
         exp_lock  = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      win         = '0;
      bus.Data_In = '0;
      t           = 0;
      model_reset();
      #3;
      vectors++;
      if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset got v=%b d=%b l=%b sym=%h exp all zero",
                  bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle();
      plan_start();
      plan_nc(200);
      foreach (plan[i]) begin
         send_bit(plan[i]);
         vectors++;
         if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !==
             {exp_valid, exp_det, exp_lock, exp_sym}) begin
            miscompares++;
            $display("FAIL idle[%0d] got v=%b d=%b l=%b sym=%h exp v=%b d=%b l=%b sym=%h", i,
                     bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol,
                     exp_valid, exp_det, exp_lock, exp_sym);
         end
      end
      vectors++;
      if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !== 13'd0) begin
         miscompares++;
         $display("FAIL idle_end got v=%b d=%b l=%b sym=%h exp all zero",
                  bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol);
      end
   endtask

   task automatic test_acquire();
      logic [9:0] d[5];
      int         m_comma;
      int         m_data[5];
      plan_start();
      plan_nc(7);
      plan_sym(10'h17C);
      m_comma = plan.size() - 1;
      for (int k = 0; k < 5; k++) begin
         d[k] = data_sym();
         plan_sym(d[k]);
         m_data[k] = plan.size() - 1;
      end
      foreach (plan[i]) begin
         send_bit(plan[i]);
         vectors++;
         if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !==
             {exp_valid, exp_det, exp_lock, exp_sym}) begin
            miscompares++;
            $display("FAIL acquire[%0d] got v=%b d=%b l=%b sym=%h exp v=%b d=%b l=%b sym=%h", i,
                     bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol,
                     exp_valid, exp_det, exp_lock, exp_sym);
         end
         if (i == m_comma) begin
            vectors++;
            if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol} !== {1'b1, 1'b1, 10'h17C}) begin
               miscompares++;
               $display("FAIL acquire_comma got v=%b d=%b sym=%h exp v=1 d=1 sym=17c",
                        bus.Symbol_Valid, bus.Comma_Det, bus.Symbol);
            end
         end
         for (int k = 0; k < 5; k++) begin
            if (i == m_data[k]) begin
               vectors++;
               if ({bus.Symbol_Valid, bus.Symbol} !== {1'b1, d[k]}) begin
                  miscompares++;
                  $display("FAIL acquire_data%0d got v=%b sym=%h exp v=1 sym=%h",
                           k, bus.Symbol_Valid, bus.Symbol, d[k]);
               end
            end
         end
      end
   endtask

   task automatic test_lock();
      int m_pre3, m_c3, m_c4;
      plan_start();
      plan_sym(data_sym());
      plan_sym(10'h283);
      plan_sym(data_sym());
      m_pre3 = plan.size() - 1;
      plan_sym(10'h17C);
      m_c3 = plan.size() - 1;
      plan_sym(data_sym());
      plan_sym(10'h283);
      m_c4 = plan.size() - 1;
      plan_sym(data_sym());
      foreach (plan[i]) begin
         send_bit(plan[i]);
         vectors++;
         if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !==
             {exp_valid, exp_det, exp_lock, exp_sym}) begin
            miscompares++;
            $display("FAIL lock[%0d] got v=%b d=%b l=%b sym=%h exp v=%b d=%b l=%b sym=%h", i,
                     bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol,
                     exp_valid, exp_det, exp_lock, exp_sym);
         end
         if (i == m_pre3 || i == m_c3 || i == m_c4) begin
            vectors++;
            if (bus.Symbol_Lock !== (i != m_pre3)) begin
               miscompares++;
               $display("FAIL lock_edge[%0d] got lock=%b exp lock=%b",
                        i, bus.Symbol_Lock, (i != m_pre3));
            end
         end
      end
   endtask

   task automatic test_slip();
      int m_slip, m_relock;
      plan_start();
      plan_sym(data_sym());
      plan_bit(~plan[$]);
      plan_sym(10'h17C);
      m_slip = plan.size() - 1;
      plan_sym(data_sym());
      plan_sym(10'h283);
      plan_sym(data_sym());
      plan_sym(10'h17C);
      m_relock = plan.size() - 1;
      plan_sym(data_sym());
      foreach (plan[i]) begin
         send_bit(plan[i]);
         vectors++;
         if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !==
             {exp_valid, exp_det, exp_lock, exp_sym}) begin
            miscompares++;
            $display("FAIL slip[%0d] got v=%b d=%b l=%b sym=%h exp v=%b d=%b l=%b sym=%h", i,
                     bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol,
                     exp_valid, exp_det, exp_lock, exp_sym);
         end
         if (i == m_slip) begin
            vectors++;
            if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !==
                {1'b1, 1'b1, 1'b0, 10'h17C}) begin
               miscompares++;
               $display("FAIL slip_comma got v=%b d=%b l=%b sym=%h exp v=1 d=1 l=0 sym=17c",
                        bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol);
            end
         end
         if (i == m_relock) begin
            vectors++;
            if (bus.Symbol_Lock !== 1'b1) begin
               miscompares++;
               $display("FAIL slip_relock got lock=%b exp lock=1", bus.Symbol_Lock);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int m_comma;
      // walk forward (never a comma) until the boundary phase reaches 4
      for (int k = 0; k < 10 && ((t - align_t) % 10) != 4; k++) begin
         plan_start();
         plan_nc(1);
         send_bit(plan[0]);
         vectors++;
         if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !==
             {exp_valid, exp_det, exp_lock, exp_sym}) begin
            miscompares++;
            $display("FAIL rst_mid_walk[%0d] got v=%b d=%b l=%b sym=%h exp v=%b d=%b l=%b sym=%h", k,
                     bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol,
                     exp_valid, exp_det, exp_lock, exp_sym);
         end
      end
      vectors++;
      if (bus.Symbol_Lock !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_prelock got lock=%b exp lock=1", bus.Symbol_Lock);
      end
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      vectors++;
      if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !== 13'd0) begin
         miscompares++;
         $display("FAIL rst_mid_async got v=%b d=%b l=%b sym=%h exp all zero",
                  bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol);
      end
      #1 rst_n = 1'b1;
      plan_start();
      plan_nc(25);
      plan_sym(10'h17C);
      m_comma = plan.size() - 1;
      plan_sym(data_sym());
      plan_sym(data_sym());
      foreach (plan[i]) begin
         send_bit(plan[i]);
         vectors++;
         if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !==
             {exp_valid, exp_det, exp_lock, exp_sym}) begin
            miscompares++;
            $display("FAIL rst_mid[%0d] got v=%b d=%b l=%b sym=%h exp v=%b d=%b l=%b sym=%h", i,
                     bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol,
                     exp_valid, exp_det, exp_lock, exp_sym);
         end
         if (i < 25) begin
            vectors++;
            if (bus.Symbol_Valid !== 1'b0) begin
               miscompares++;
               $display("FAIL rst_mid_novalid[%0d] got v=%b exp v=0", i, bus.Symbol_Valid);
            end
         end
         if (i == m_comma) begin
            vectors++;
            if ({bus.Symbol_Valid, bus.Symbol} !== {1'b1, 10'h17C}) begin
               miscompares++;
               $display("FAIL rst_mid_reacq got v=%b sym=%h exp v=1 sym=17c",
                        bus.Symbol_Valid, bus.Symbol);
            end
         end
      end
   endtask

   task automatic test_random();
      plan_start();
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 9) == 0) plan_bit(~plan_win[9]);
         case ($urandom_range(0, 3))
            0:       plan_sym($urandom_range(0, 1) ? 10'h17C : 10'h283);
            default: plan_sym(data_sym());
         endcase
      end
      foreach (plan[i]) begin
         send_bit(plan[i]);
         vectors++;
         if ({bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol} !==
             {exp_valid, exp_det, exp_lock, exp_sym}) begin
            miscompares++;
            $display("FAIL random[%0d] got v=%b d=%b l=%b sym=%h exp v=%b d=%b l=%b sym=%h", i,
                     bus.Symbol_Valid, bus.Comma_Det, bus.Symbol_Lock, bus.Symbol,
                     exp_valid, exp_det, exp_lock, exp_sym);
         end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_acquire();
      test_lock();
      test_slip();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
